soc_multi_timer: RTL and testbench
==================================

Name: soc_multi_timer

Overview:
Parametrised multi-channel interval timer on an Avalon-MM slave. It succeeds the single-channel 16-bit-bus timer. Each of NUM_CH independent channels has a configurable-width down-counter, a per-channel clock prescaler, one-shot or continuous mode, a snapshot register and its own interrupt. Per-channel interrupts are OR-combined onto one CPU IRQ line, and the raw vector is also exported.

Parameters:
NUM_CH, 4, number of channels; legal range 1..8.
COUNT_W, 32, counter and period width; legal range 8..32. Upper bits of registers read as 0.
RESET_PERIOD, 9999, period and counter value at reset, truncated to COUNT_W.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  5  word address; [4:2] = channel, [1:0] = register
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
read_n  in  1  active-low read strobe; readdata updates regardless
writedata  in  32  write data
readdata  out  32  registered read data
irq  out  1  OR of irq_vec
irq_vec  out  NUM_CH  per-channel interrupt

Behaviour:
- Reset is applied asynchronously on reset=1:
  - readdata=0, irq=0, irq_vec=0;
  - per channel: counter=period=RESET_PERIOD, control=0, prescale count=0, TO=0, RUN=0, snapshot=0.
- Register map per channel (reg = address[1:0]):
  - 0 STATUS: bit0 TO, bit1 RUN. Any write clears TO.
  - 1 CONTROL: bit0 ITO (irq enable), bit1 CONT, bit2 START (write-only pulse), bit3 STOP (write-only pulse), bits[15:8] PS. Stored as written except bits 2/3, which read 0.
  - 2 PERIOD: COUNT_W bits.
  - 3 SNAP: any write latches the current counter. Reads return the latched value.
- Channel index >= NUM_CH: reads return 0, writes are ignored.
- Write strobe = chipselect & ~write_n. Read mux output is registered, so read latency is 1 cycle.
- Tick generation:
  - Per-channel prescaler counts 0..PS while RUN=1.
  - tick=1 on the cycle where prescale count == PS, after which the count returns to 0.
  - PS=0 means a tick every cycle.
  - Prescale count clears on START, on a PERIOD write and while RUN=0.
- Counter, on a tick while RUN=1:
  - counter!=0: decrement.
  - counter==0: reload from period, raise a timeout event (1 cycle), and clear RUN if CONT=0.
  - One period therefore lasts (P+1)*(PS+1) clocks.
- PERIOD write:
  - Next cycle: counter <= new period, prescale count <= 0, RUN <= 0 (force-reload; software must restart).
  - PERIOD write in the same cycle as START: reload happens and RUN ends at 1.
- START and STOP in the same write: START wins, RUN=1. START while already running: the counter is not reloaded, only the prescaler is cleared.
- TO:
  - Set by a timeout event.
  - A STATUS write coinciding with a timeout event leaves TO=1 (set wins, no lost events).
- irq_vec[i] = TO[i] & ITO[i], combinational from registers. irq = |irq_vec.
- Period=0 with CONT=1: a timeout on every tick. TO stays 1, with no edge-detect dependency.
- Snapshot write coinciding with a counter update captures the pre-update value.
- Reset asserted mid-count returns all state to reset values immediately. The counter does not run until START.

Test Plan:
- Reset release, read ch0 STATUS/PERIOD/CONTROL -> readdata 0x0, 9999 (0x270F), 0x0, each exactly 1 cycle after the read.
- ch1: PERIOD=4, CONTROL=0x5 (START|ITO), PS=0 -> TO and irq_vec[1] rise 5 clocks after START takes effect, RUN drops, counter reloads to 4, irq=1. STATUS write -> irq=0.
- ch2: PERIOD=2, CONTROL=0x0307 (CONT|ITO|START, PS=3) -> timeout every 12 clocks, RUN stays 1. Write STATUS on the exact timeout cycle -> TO remains 1.
- ch0 running continuous with PERIOD=100: write SNAP when counter=57 -> SNAP reads 57. Write PERIOD=10 mid-count -> RUN=0, counter=10, no timeout raised.
- CONTROL write with START|STOP (0xC) -> RUN=1. Write STOP only (0x8) -> RUN=0, counter frozen, prescale count cleared.
- NUM_CH=2, COUNT_W=16: access to channel 3 reads 0 and writes have no effect. PERIOD write 0x12345 reads back 0x2345. Reset asserted mid-count -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/soc_multi_timer_if.sv
// soc_multi_timer_if: Avalon-MM slave bus plus interrupt outputs of the multi-channel timer
interface soc_multi_timer_if #(
    parameter int NUM_CH = 4
);
    logic [4:0]        address;
    logic              chipselect;
    logic              write_n;
    logic              read_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;
    logic [NUM_CH-1:0] irq_vec;
    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata, irq, irq_vec
    );
    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata, irq, irq_vec
    );
endinterface

// File: rtl/soc_multi_timer.sv
// soc_multi_timer: NUM_CH prescaled down-counter timers with snapshot and per-channel IRQ on Avalon-MM
module soc_multi_timer #(
    parameter int NUM_CH       = 4,
    parameter int COUNT_W      = 32,
    parameter int RESET_PERIOD = 9999
) (
    input logic              clk,
    input logic              reset,
    soc_multi_timer_if.slave bus
);
    logic              wr;
    logic              unused_ok;
    logic [31:0]       ch_rd [8];
    logic [NUM_CH-1:0] irq_v;
    logic [31:0]       rd_q;
    assign wr        = bus.chipselect & ~bus.write_n;
    assign unused_ok = bus.read_n;
    for (genvar c = 0; c < 8; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            logic [COUNT_W-1:0] cnt_q, cnt_d, per_q, per_d, snap_q, snap_d;
            logic [31:0]        ctl_q, ctl_d;
            logic [7:0]         psc_q, psc_d;
            logic               to_q, to_d, run_q, run_d;
            logic               sel, tick, tmo, start, stop, wr_per;
            always_comb begin
                sel    = wr && bus.address[4:2] == 3'(c);
                start  = sel && bus.address[1:0] == 2'd1 && bus.writedata[2];
                stop   = sel && bus.address[1:0] == 2'd1 && bus.writedata[3];
                wr_per = sel && bus.address[1:0] == 2'd2;
                tick   = run_q && psc_q == ctl_q[15:8];
                // a PERIOD write force-reloads, so it suppresses a coinciding timeout
                tmo    = tick && cnt_q == '0 && !wr_per;
                psc_d  = (start || wr_per || !run_q || tick) ? 8'd0 : psc_q + 8'd1;
                cnt_d  = wr_per ? bus.writedata[COUNT_W-1:0] :
                         (start && !run_q) ? per_q :
                         !tick ? cnt_q :
                         cnt_q == '0 ? per_q : cnt_q - COUNT_W'(1);
                run_d  = start || (run_q && !wr_per && !stop && !(tmo && !ctl_q[1]));
                to_d   = tmo || (to_q && !(sel && bus.address[1:0] == 2'd0));
                per_d  = wr_per ? bus.writedata[COUNT_W-1:0] : per_q;
                ctl_d  = (sel && bus.address[1:0] == 2'd1) ? (bus.writedata & ~32'hC) : ctl_q;
                snap_d = (sel && bus.address[1:0] == 2'd3) ? cnt_q : snap_q;
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q  <= COUNT_W'(RESET_PERIOD);
                    per_q  <= COUNT_W'(RESET_PERIOD);
                    snap_q <= '0;
                    ctl_q  <= '0;
                    psc_q  <= '0;
                    to_q   <= 1'b0;
                    run_q  <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    per_q  <= per_d;
                    snap_q <= snap_d;
                    ctl_q  <= ctl_d;
                    psc_q  <= psc_d;
                    to_q   <= to_d;
                    run_q  <= run_d;
                end
            end
            assign irq_v[c] = to_q & ctl_q[0];
            assign ch_rd[c] = bus.address[1:0] == 2'd0 ? {30'd0, run_q, to_q} :
                              bus.address[1:0] == 2'd1 ? ctl_q :
                              bus.address[1:0] == 2'd2 ? 32'(per_q) : 32'(snap_q);
        end else begin : g_off
            assign ch_rd[c] = '0;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_q <= '0;
        else       rd_q <= ch_rd[bus.address[4:2]];
    end
    assign bus.readdata = rd_q;
    assign bus.irq_vec  = irq_v;
    assign bus.irq      = |irq_v;
endmodule

// File: tb/tb_soc_multi_timer.sv
// tb_soc_multi_timer: scoreboard bench for a default 4x32 timer and a reduced 2x16 timer
module tb_soc_multi_timer;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    logic [31:0] exp_q [$];
    always #5 clk = ~clk;
    soc_multi_timer_if #(.NUM_CH(4)) a ();
    soc_multi_timer_if #(.NUM_CH(2)) b ();
    soc_multi_timer #(.NUM_CH(4)) u_a (.clk(clk), .reset(rst_a), .bus(a));
    soc_multi_timer #(.NUM_CH(2), .COUNT_W(16)) u_b (.clk(clk), .reset(rst_b), .bus(b));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else pass_cnt++;
    endtask
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic drv(input bit d, input logic [4:0] adr, input logic w, input logic [31:0] dat);
        if (d) begin
            b.address = adr; b.chipselect = 1'b1; b.write_n = !w; b.read_n = w; b.writedata = dat;
        end else begin
            a.address = adr; a.chipselect = 1'b1; a.write_n = !w; a.read_n = w; a.writedata = dat;
        end
        cyc(1);
        if (d) begin
            b.chipselect = 1'b0; b.write_n = 1'b1; b.read_n = 1'b1;
        end else begin
            a.chipselect = 1'b0; a.write_n = 1'b1; a.read_n = 1'b1;
        end
    endtask
    task automatic wr(input bit d, input logic [2:0] ch, input logic [1:0] r, input logic [31:0] dat);
        drv(d, {ch, r}, 1'b1, dat);
    endtask
    task automatic rd(input bit d, input logic [2:0] ch, input logic [1:0] r, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        drv(d, {ch, r}, 1'b0, 32'd0);
        check(tag, d ? b.readdata : a.readdata, exp_q.pop_front());
    endtask
    initial begin
        a.address = '0; a.chipselect = 1'b0; a.write_n = 1'b1; a.read_n = 1'b1; a.writedata = '0;
        b.address = '0; b.chipselect = 1'b0; b.write_n = 1'b1; b.read_n = 1'b1; b.writedata = '0;
        cyc(2);
        check("rst_readdata", a.readdata, 32'd0);
        check("rst_irq", 32'(a.irq), 32'd0);
        check("rst_irq_vec", 32'(a.irq_vec), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        cyc(1);
        rd(0, 3'd0, 2'd0, 32'h0, "ch0_status");
        rd(0, 3'd0, 2'd2, 32'h270F, "ch0_period");
        rd(0, 3'd0, 2'd1, 32'h0, "ch0_control");
        // ch1 one-shot, period 4, no prescale
        wr(0, 3'd1, 2'd2, 32'd4);
        wr(0, 3'd1, 2'd1, 32'h5);
        cyc(4);
        check("ch1_before_to", 32'(a.irq_vec), 32'h0);
        cyc(1);
        check("ch1_irq_vec", 32'(a.irq_vec), 32'h2);
        check("ch1_irq", 32'(a.irq), 32'd1);
        rd(0, 3'd1, 2'd0, 32'h1, "ch1_status");
        wr(0, 3'd1, 2'd3, 32'd0);
        rd(0, 3'd1, 2'd3, 32'd4, "ch1_reload");
        wr(0, 3'd1, 2'd0, 32'd0);
        check("ch1_irq_clr", 32'(a.irq), 32'd0);
        // ch2 continuous, period 2, prescale 3 -> 12 clocks per timeout
        wr(0, 3'd2, 2'd2, 32'd2);
        wr(0, 3'd2, 2'd1, 32'h0307);
        cyc(11);
        check("ch2_before_to", 32'(a.irq_vec), 32'h0);
        cyc(1);
        check("ch2_to1", 32'(a.irq_vec), 32'h4);
        wr(0, 3'd2, 2'd0, 32'd0);
        check("ch2_clr", 32'(a.irq_vec), 32'h0);
        cyc(10);
        wr(0, 3'd2, 2'd0, 32'd0);
        check("ch2_set_wins", 32'(a.irq_vec), 32'h4);
        rd(0, 3'd2, 2'd0, 32'h3, "ch2_status");
        wr(0, 3'd2, 2'd1, 32'h8);
        wr(0, 3'd2, 2'd0, 32'd0);
        check("ch2_stopped_irq", 32'(a.irq), 32'd0);
        rd(0, 3'd2, 2'd1, 32'h0, "ch2_ctl_pulse_rd0");
        // ch0 snapshot mid-count, then force-reload by PERIOD write
        wr(0, 3'd0, 2'd2, 32'd100);
        wr(0, 3'd0, 2'd1, 32'h6);
        cyc(43);
        wr(0, 3'd0, 2'd3, 32'd0);
        rd(0, 3'd0, 2'd3, 32'd57, "ch0_snap57");
        wr(0, 3'd0, 2'd2, 32'd10);
        rd(0, 3'd0, 2'd0, 32'h0, "ch0_per_stop");
        wr(0, 3'd0, 2'd3, 32'd0);
        rd(0, 3'd0, 2'd3, 32'd10, "ch0_per_reload");
        // START|STOP together starts; STOP alone freezes
        wr(0, 3'd0, 2'd1, 32'hC);
        rd(0, 3'd0, 2'd0, 32'h2, "ch0_startstop");
        wr(0, 3'd0, 2'd1, 32'h8);
        rd(0, 3'd0, 2'd0, 32'h0, "ch0_stop");
        wr(0, 3'd0, 2'd3, 32'd0);
        rd(0, 3'd0, 2'd3, 32'd8, "ch0_frozen_a");
        cyc(5);
        wr(0, 3'd0, 2'd3, 32'd0);
        rd(0, 3'd0, 2'd3, 32'd8, "ch0_frozen_b");
        // reduced instance: missing channels and truncated width
        rd(1, 3'd3, 2'd2, 32'h0, "b_ch3_rd");
        wr(1, 3'd3, 2'd2, 32'h55);
        wr(1, 3'd3, 2'd1, 32'h5);
        rd(1, 3'd3, 2'd1, 32'h0, "b_ch3_ctl");
        rd(1, 3'd1, 2'd2, 32'h270F, "b_ch1_per");
        rd(1, 3'd0, 2'd2, 32'h270F, "b_ch0_per");
        check("b_ch3_irq", 32'(b.irq), 32'd0);
        wr(1, 3'd0, 2'd2, 32'h12345);
        rd(1, 3'd0, 2'd2, 32'h2345, "b_trunc");
        // period 0 continuous: timeout on every tick
        wr(1, 3'd0, 2'd2, 32'd0);
        wr(1, 3'd0, 2'd1, 32'h7);
        cyc(1);
        check("b_p0_irq", 32'(b.irq), 32'd1);
        wr(1, 3'd0, 2'd0, 32'd0);
        check("b_p0_stays", 32'(b.irq_vec), 32'h1);
        cyc(2);
        rd(1, 3'd0, 2'd0, 32'h3, "b_p0_status");
        #1 rst_b = 1'b1;
        #2;
        check("b_async_rd", b.readdata, 32'd0);
        check("b_async_irq", 32'(b.irq), 32'd0);
        check("b_async_vec", 32'(b.irq_vec), 32'd0);
        cyc(1);
        rst_b = 1'b0;
        cyc(3);
        rd(1, 3'd0, 2'd0, 32'h0, "b_post_rst_status");
        wr(1, 3'd0, 2'd3, 32'd0);
        rd(1, 3'd0, 2'd3, 32'h270F, "b_post_rst_cnt");
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
